slow_dac_ctrl: RTL and testbench
================================

# slow_dac_ctrl

Sequencer and arbiter in front of the slow DAC serializer. Two requesters (A: host register writes, B: sweep/feedback engine) write 16-bit codes into a 4-channel shadow bank through a round-robin arbiter. The controller owns the serializer's `data`/`cmd`/`valid` inputs and commits the shadow bank only at frame boundaries, so a serializer frame never sees torn data. It sits between the register/sweep logic and the DAC serializer, in the same clock domain.

## Interface
- `CLK_DIV`, default 3: must equal the serializer's `CLK_DIV`, minimum 1. Frame length F = 128·2^CLK_DIV clk cycles.
- `clk` in 1: system clock. All logic is on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `enable` in 1: run request for the DAC frame loop.
- `cfg_cmd` in 4: DAC command nibble, sampled at commit.
- `a_req` in 1: requester A write request. Hold until `a_ack`.
- `a_chan` in 2: requester A target channel.
- `a_data` in 16: requester A code.
- `a_ack` out 1: one-cycle accept pulse for requester A.
- `b_req`, `b_chan`, `b_data`, `b_ack`: requester B, identical to A.
- `dac_data` out 64: to serializer `data`. Channel c occupies bits [16c+15:16c].
- `dac_cmd` out 4: to serializer `cmd`.
- `dac_valid` out 1: to serializer `valid`.
- `commit` out 1: one-cycle pulse when the shadow bank is copied to `dac_data`.
- `pending` out 4: per channel, set when the shadow differs from what was last committed.
- `busy` out 1: high while in state RUN.

## Operation
- Reset values: `dac_data`=0, `dac_cmd`=0, `dac_valid`=0, `a_ack`=`b_ack`=0, `commit`=0, `pending`=0, `busy`=0. Shadow bank is 0, state is IDLE, `frame_cnt`=0, round-robin pointer is A.
- Arbiter:
  - Requests are sampled each cycle. At most one grant per cycle.
  - A requester whose ack is high in the current cycle is ineligible in that cycle.
  - If both requesters are eligible, the pointer side wins. After any grant, the pointer moves to the other side.
  - A single eligible requester always wins.
  - On grant, the next cycle carries: ack=1, `shadow[chan]`<=data, and `pending[chan]`<=1.
- Writes are accepted in every state, including IDLE. Back-to-back writes to the same channel: the last write wins.
- State machine:
  - IDLE: `dac_valid`=0. When `enable`=1, perform a commit and go to RUN.
  - RUN: `dac_valid`=1. `frame_cnt` (width 7+CLK_DIV) counts 0..F-1 and wraps. At `frame_cnt`=F-1:
    - if `enable`=1, commit and stay in RUN;
    - else go to IDLE with no commit.
- Commit copies the shadow bank to `dac_data` and `cfg_cmd` to `dac_cmd`, pulses `commit`, and clears `pending`.
- Write and commit in the same cycle: the commit takes the pre-write shadow value. The written channel's `pending` stays 1 (set beats clear).
- `dac_data` and `dac_cmd` change only at commit, so they are constant for the whole frame. This matters because the serializer reads `cmd` live throughout the frame.

## Timing
- Write latency: request sampled at edge t → ack and shadow update visible after t+1. The earliest re-accept for the same requester is t+2.
- Start: `enable` sampled high in IDLE at edge t → after t+1: `dac_valid`=1, `frame_cnt`=0, `commit`=1, new `dac_data` valid.
- The serializer latches data at `frame_cnt`=2^(CLK_DIV-1)-1 in every frame. `dac_data` is always updated at least one cycle before that point.
- Steady-state commit: at `frame_cnt`=F-1, the new data is visible from `frame_cnt`=0 of the next frame. Commit period is exactly F cycles.
- Stop: `enable` low at any point in a frame → `dac_valid` falls on the cycle after `frame_cnt`=F-1. The frame always completes.
  - If `enable` returns high before F-1, the stop is cancelled.
- `resetn` asserted mid-frame: all outputs go immediately to their reset values and `dac_valid` drops asynchronously. Acks in flight are lost; requesters re-issue.

## Test plan
- Reset, then `enable`=1 with no writes → `dac_valid` rises the next cycle with `dac_data`=0 and `commit`=1. Subsequent `commit` pulses occur every 1024 cycles (CLK_DIV=3).
- In IDLE: A writes ch2=0x1234, then `enable`=1 → `a_ack` one cycle after the request, `pending`=4'b0100. The first commit gives `dac_data[47:32]`=0x1234 and `pending`=0.
- A and B both held high, pointer at A:
  - grants alternate A,B,A,…;
  - each requester gets at most one ack per 2 cycles;
  - B on ch1=0xBEEF and A on ch1=0x0001 → the last ack'd value is the one committed.
- In RUN: write ch0=0xAAAA exactly at `frame_cnt`=1023 → the commit delivers the old ch0, `pending[0]` stays 1, and 0xAAAA is committed 1024 cycles later.
- Drop `enable` at `frame_cnt`=100 → `dac_valid` stays high until after `frame_cnt`=1023, then goes 0 with no commit pulse. Repeat with `enable` re-raised at 500 → no stop.
- Pulse `resetn` low at `frame_cnt`=300 → `dac_valid`, `dac_data`, and `pending` go to 0 immediately. After release with `enable`=1, the restart follows the start timing.

Source files
------------

// File: rtl/slow_dac_ctrl.sv
// slow_dac_ctrl
// Sequencer and arbiter in front of the slow DAC serializer. Two requesters
// write 16-bit codes into a 4-channel shadow bank through a round-robin
// arbiter. The shadow bank is copied to dac_data only at frame boundaries,
// so the serializer never sees a frame with torn data.
//
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   enable               run request for the DAC frame loop
//   cfg_cmd[3:0]         DAC command nibble, captured at commit
//   a_req/a_chan/a_data  requester A write (hold a_req until a_ack)
//   a_ack                one-cycle accept pulse for requester A
//   b_*                  requester B, identical to A
//   dac_data[63:0]       serializer data, channel c in bits [16c+15:16c]
//   dac_cmd[3:0]         serializer command
//   dac_valid            serializer valid (high while running)
//   commit               one-cycle pulse when the shadow bank is committed
//   pending[3:0]         per channel: shadow differs from last commit
//   busy                 high while in RUN
module slow_dac_ctrl #(
    parameter int CLK_DIV = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [3:0]  cfg_cmd,
    input  logic        a_req,
    input  logic [1:0]  a_chan,
    input  logic [15:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic [1:0]  b_chan,
    input  logic [15:0] b_data,
    output logic        b_ack,
    output logic [63:0] dac_data,
    output logic [3:0]  dac_cmd,
    output logic        dac_valid,
    output logic        commit,
    output logic [3:0]  pending,
    output logic        busy
);

    localparam int CW = 7 + CLK_DIV;
    localparam logic [CW-1:0] FRAME_LAST = {CW{1'b1}};
    localparam logic [CW-1:0] FRAME_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] frame_cnt_r, frame_nxt_s;
    logic          ptr_r, ptr_nxt_s;          // 0: A has priority, 1: B
    logic [15:0]   shadow_r [4];
    logic          a_ack_r, b_ack_r;
    logic [63:0]   dac_data_r;
    logic [3:0]    dac_cmd_r;
    logic          dac_valid_r, commit_r, busy_r;
    logic [3:0]    pending_r, pend_nxt_s;

    logic          elig_a_s, elig_b_s, grant_a_s, grant_b_s, wr_en_s;
    logic [1:0]    wr_chan_s;
    logic [15:0]   wr_data_s;
    logic          commit_s;

    // Round-robin arbiter: a requester whose ack is high this cycle sits out.
    always_comb begin
        elig_a_s  = a_req & ~a_ack_r;
        elig_b_s  = b_req & ~b_ack_r;
        grant_a_s = elig_a_s & (~elig_b_s | ~ptr_r);
        grant_b_s = elig_b_s & (~elig_a_s | ptr_r);
        wr_en_s   = grant_a_s | grant_b_s;
        wr_chan_s = 2'd0;
        wr_data_s = 16'h0000;
        ptr_nxt_s = ptr_r;
        if (grant_a_s) begin
            wr_chan_s = a_chan;
            wr_data_s = a_data;
            ptr_nxt_s = 1'b1;
        end else if (grant_b_s) begin
            wr_chan_s = b_chan;
            wr_data_s = b_data;
            ptr_nxt_s = 1'b0;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Frame sequencer next-state: commit on start and at the last frame cycle.
    always_comb begin
        state_nxt_s = state_r;
        frame_nxt_s = frame_cnt_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                frame_nxt_s = {CW{1'b0}};
                if (enable) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_cnt_r == FRAME_LAST) begin
                    frame_nxt_s = {CW{1'b0}};
                    if (enable) begin
                        commit_s    = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    frame_nxt_s = frame_cnt_r + FRAME_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                frame_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // Pending flags: commit clears, a same-cycle write sets (set wins).
    always_comb begin
        if (commit_s) begin
            pend_nxt_s = 4'b0000;
        end else begin
            pend_nxt_s = pending_r;
        end
        if (wr_en_s) begin
            pend_nxt_s[wr_chan_s] = 1'b1;
        end else begin
            pend_nxt_s = pend_nxt_s;
        end
    end

    // State and frame counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= {CW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_nxt_s;
        end
    end

    // Shadow bank write port; commit reads the pre-write contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) shadow_r[i] <= 16'h0000;
        end else if (wr_en_s) begin
            shadow_r[wr_chan_s] <= wr_data_s;
        end
    end

    // Registered outputs: acks, pointer, pending, commit and the DAC word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r       <= 1'b0;
            a_ack_r     <= 1'b0;
            b_ack_r     <= 1'b0;
            pending_r   <= 4'b0000;
            commit_r    <= 1'b0;
            dac_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            dac_data_r  <= 64'h0;
            dac_cmd_r   <= 4'h0;
        end else begin
            ptr_r       <= ptr_nxt_s;
            a_ack_r     <= grant_a_s;
            b_ack_r     <= grant_b_s;
            pending_r   <= pend_nxt_s;
            commit_r    <= commit_s;
            dac_valid_r <= (state_nxt_s == ST_RUN);
            busy_r      <= (state_nxt_s == ST_RUN);
            if (commit_s) begin
                dac_data_r <= {shadow_r[3], shadow_r[2], shadow_r[1], shadow_r[0]};
                dac_cmd_r  <= cfg_cmd;
            end
        end
    end

    assign a_ack     = a_ack_r;
    assign b_ack     = b_ack_r;
    assign pending   = pending_r;
    assign commit    = commit_r;
    assign dac_valid = dac_valid_r;
    assign busy      = busy_r;
    assign dac_data  = dac_data_r;
    assign dac_cmd   = dac_cmd_r;

endmodule

// File: tb/tb_slow_dac_ctrl.sv
// Self-checking bench for slow_dac_ctrl (CLK_DIV=3, frame = 1024 cycles).
// Inputs are driven 1 time unit after the rising edge and outputs are
// compared at the same point, i.e. away from the active edge.
module tb_slow_dac_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [3:0]  cfg_cmd;
    logic        a_req, b_req;
    logic [1:0]  a_chan, b_chan;
    logic [15:0] a_data, b_data;
    logic        a_ack, b_ack;
    logic [63:0] dac_data;
    logic [3:0]  dac_cmd;
    logic        dac_valid, commit, busy;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    slow_dac_ctrl #(.CLK_DIV(3)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .cfg_cmd(cfg_cmd),
        .a_req(a_req), .a_chan(a_chan), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_chan(b_chan), .b_data(b_data), .b_ack(b_ack),
        .dac_data(dac_data), .dac_cmd(dac_cmd), .dac_valid(dac_valid),
        .commit(commit), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_req;
        logic [1:0]  a_chan;
        logic [15:0] a_data;
        logic        b_req;
        logic [1:0]  b_chan;
        logic [15:0] b_data;
        logic        en;
        logic        exp_a_ack;
        logic        exp_b_ack;
        logic [3:0]  exp_pend;
        logic        exp_commit;
        logic        exp_valid;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n cycles and count commit pulses and valid-low cycles seen.
    task automatic run(input int n, output int n_commit, output int n_novalid);
        n_commit  = 0;
        n_novalid = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (commit === 1'b1) n_commit++;
            if (dac_valid !== 1'b1) n_novalid++;
        end
    endtask

    int nc, nv;

    initial begin
        // IDLE arbitration, then a start; pointer begins at A.
        vecs[0] = '{1'b1, 2'd2, 16'h1234, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 2'd1, 16'h0001, 1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[3] = '{1'b1, 2'd1, 16'h0001, 1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 2'd1, 16'h0001, 1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 2'd1, 16'h0001, 1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[6] = '{1'b0, 2'd1, 16'h0001, 1'b1, 2'd1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[7] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 64'h0};
        vecs[8] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1,
                    64'h0000_1234_BEEF_0000};

        resetn = 1'b0; enable = 1'b0; cfg_cmd = 4'hA;
        a_req = 1'b0; a_chan = 2'd0; a_data = 16'h0;
        b_req = 1'b0; b_chan = 2'd0; b_data = 16'h0;
        #3;
        chk("reset_data",    dac_data,  64'h0);
        chk("reset_valid",   dac_valid, 1'b0);
        chk("reset_pending", pending,   4'b0000);
        chk("reset_acks",    {a_ack, b_ack, commit, busy}, 4'b0000);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("idle_valid", dac_valid, 1'b0);

        for (int i = 0; i < 9; i++) begin
            a_req = vecs[i].a_req; a_chan = vecs[i].a_chan; a_data = vecs[i].a_data;
            b_req = vecs[i].b_req; b_chan = vecs[i].b_chan; b_data = vecs[i].b_data;
            enable = vecs[i].en;
            tick();
            chk($sformatf("v%0d_a_ack", i),   a_ack,     vecs[i].exp_a_ack);
            chk($sformatf("v%0d_b_ack", i),   b_ack,     vecs[i].exp_b_ack);
            chk($sformatf("v%0d_pending", i), pending,   vecs[i].exp_pend);
            chk($sformatf("v%0d_commit", i),  commit,    vecs[i].exp_commit);
            chk($sformatf("v%0d_valid", i),   dac_valid, vecs[i].exp_valid);
            chk($sformatf("v%0d_data", i),    dac_data,  vecs[i].exp_data);
        end
        chk("start_cmd",  dac_cmd, 4'hA);
        chk("start_busy", busy,    1'b1);

        // Frame 1: command change mid-frame must not reach dac_cmd early.
        run(500, nc, nv);
        cfg_cmd = 4'h3;
        chk("f1_no_commit_a", nc, 0);
        run(523, nc, nv);              // now at frame_cnt 1023
        chk("f1_no_commit_b", nc, 0);
        chk("f1_cmd_hold", dac_cmd, 4'hA);
        chk("f1_valid_cycles", nv, 0);
        // Write ch0 exactly at frame_cnt 1023: commit takes the old ch0.
        a_req = 1'b1; a_chan = 2'd0; a_data = 16'hAAAA;
        tick();
        a_req = 1'b0;
        chk("f1_commit",   commit,   1'b1);
        chk("f1_ack",      a_ack,    1'b1);
        chk("f1_old_ch0",  dac_data, 64'h0000_1234_BEEF_0000);
        chk("f1_pend_set", pending,  4'b0001);
        chk("f1_cmd_new",  dac_cmd,  4'h3);

        // Frame 2: the late write lands one frame later.
        run(1023, nc, nv);
        chk("f2_no_commit", nc, 0);
        tick();
        chk("f2_commit",  commit,   1'b1);
        chk("f2_data",    dac_data, 64'h0000_1234_BEEF_AAAA);
        chk("f2_pending", pending,  4'b0000);

        // Stop: enable dropped at frame_cnt 100, frame still completes.
        run(100, nc, nv);
        enable = 1'b0;
        run(923, nc, nv);              // frame_cnt 1023
        chk("stop_valid_held", nv, 0);
        chk("stop_no_commit_a", nc, 0);
        tick();
        chk("stop_valid", dac_valid, 1'b0);
        chk("stop_commit", commit, 1'b0);
        chk("stop_busy", busy, 1'b0);
        run(5, nc, nv);
        chk("stop_idle", nv, 5);

        // Restart, then cancel a stop by re-raising enable at 500.
        enable = 1'b1;
        tick();
        chk("restart_commit", commit, 1'b1);
        chk("restart_valid", dac_valid, 1'b1);
        run(100, nc, nv);
        enable = 1'b0;
        run(400, nc, nv);
        enable = 1'b1;
        run(523, nc, nv);
        chk("cancel_valid_held", nv, 0);
        tick();
        chk("cancel_commit", commit, 1'b1);
        chk("cancel_valid", dac_valid, 1'b1);

        // Mid-frame reset at frame_cnt 300 with a pending write outstanding.
        run(199, nc, nv);              // frame_cnt 199
        a_req = 1'b1; a_chan = 2'd3; a_data = 16'h5555;
        tick();
        a_req = 1'b0;
        chk("pre_rst_pend", pending, 4'b1000);
        run(100, nc, nv);              // frame_cnt 300
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_valid",   dac_valid, 1'b0);
        chk("rst_data",    dac_data,  64'h0);
        chk("rst_pending", pending,   4'b0000);
        chk("rst_flags",   {commit, busy, a_ack, b_ack}, 4'b0000);
        tick();
        resetn = 1'b1;
        tick();
        chk("rst_restart_commit", commit, 1'b1);
        chk("rst_restart_valid",  dac_valid, 1'b1);
        chk("rst_restart_data",   dac_data, 64'h0);
        tick();
        chk("rst_commit_pulse", commit, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
